// File: rtl/char_text_buffer_pkg.sv
// -----------------------------------------------------------------------------
// char_text_buffer_pkg
// Shared definitions for the character text buffer:
//   - sequencer state encoding (IDLE / CLEAR / LOAD)
//   - fixed character codes (space, NUL)
//   - message table indices and message lengths
// -----------------------------------------------------------------------------
package char_text_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2
  } seq_state_t;

  localparam logic [6:0] CHAR_SPACE = 7'h20;
  localparam logic [6:0] CHAR_NUL   = 7'h00;
  localparam int         MSG_COUNT  = 4;

  localparam logic [1:0] MSG_SINGLE   = 2'd0;
  localparam logic [1:0] MSG_MULTI    = 2'd1;
  localparam logic [1:0] MSG_GAMEOVER = 2'd2;
  localparam logic [1:0] MSG_START    = 2'd3;

  localparam int MSG_LEN_SINGLE   = 13;  // "Single Player"
  localparam int MSG_LEN_MULTI    = 12;  // "Multi Player"
  localparam int MSG_LEN_GAMEOVER = 9;   // "Game Over"
  localparam int MSG_LEN_START    = 11;  // "Press Start"

endpackage

// File: rtl/char_text_buffer_msg_rom.sv
// -----------------------------------------------------------------------------
// char_msg_rom
// Combinational message table. Returns character idx of message msg_sel,
// or NUL once idx runs past the end of the message.
// Ports:
//   msg_sel  in  2       message index
//   idx      in  5       character position within the message
//   code     out CODE_W  character code (NUL past the end)
// -----------------------------------------------------------------------------
module char_msg_rom
  import char_text_buffer_pkg::*;
#(
  parameter int CODE_W = 7
) (
  input  logic [1:0]        msg_sel,
  input  logic [4:0]        idx,
  output logic [CODE_W-1:0] code
);

  localparam logic [8*MSG_LEN_SINGLE-1:0]   STR_SINGLE   = "Single Player";
  localparam logic [8*MSG_LEN_MULTI-1:0]    STR_MULTI    = "Multi Player";
  localparam logic [8*MSG_LEN_GAMEOVER-1:0] STR_GAMEOVER = "Game Over";
  localparam logic [8*MSG_LEN_START-1:0]    STR_START    = "Press Start";

  // Strings are packed first-character-in-the-MSBs, so character i of a
  // len-character string sits in byte (len-1-i). Strings are zero-padded to
  // 16 bytes on the left so one helper covers all of them.
  function automatic logic [6:0] pick(input logic [8*16-1:0] s,
                                      input int len, input int i);
    logic [6:0] ch;
    ch = CHAR_NUL;
    if (i < len) ch = s[8*(len-1-i) +: 7];
    return ch;
  endfunction

  logic [6:0] ch;

  always_comb begin
    ch = CHAR_NUL;
    case (msg_sel)
      MSG_SINGLE:   ch = pick({24'h0, STR_SINGLE},   MSG_LEN_SINGLE,   int'(idx));
      MSG_MULTI:    ch = pick({32'h0, STR_MULTI},    MSG_LEN_MULTI,    int'(idx));
      MSG_GAMEOVER: ch = pick({56'h0, STR_GAMEOVER}, MSG_LEN_GAMEOVER, int'(idx));
      MSG_START:    ch = pick({40'h0, STR_START},    MSG_LEN_START,    int'(idx));
      default:      ch = CHAR_NUL;
    endcase
    code = CODE_W'(ch);
  end

endmodule

// File: rtl/char_text_buffer.sv
// -----------------------------------------------------------------------------
// char_text_buffer
// COLS x ROWS character-code buffer with a built-in message loader and clear
// sequencer. The pixel path reads cells by address; game logic either writes
// single cells directly or issues one-shot clear / message-load commands.
// Ports:
//   clk        in   1       system clock
//   rst        in   1       synchronous active-high reset (starts a full clear)
//   char_xy    in   ADDR_W  read address {row, col}
//   code       out  CODE_W  registered character at char_xy (1-cycle latency)
//   wr_en      in   1       direct write strobe (ignored while busy)
//   wr_addr    in   ADDR_W  direct write address
//   wr_code    in   CODE_W  direct write data
//   clr        in   1       pulse: fill buffer with spaces
//   msg_load   in   1       pulse: copy message msg_sel starting at load_addr
//   msg_sel    in   2       message index
//   load_addr  in   ADDR_W  first cell for the message
//   busy       out  1       sequencer active; commands and wr_en ignored
//
// Handshake: commands are single-cycle pulses accepted only while busy=0;
// there is no ready/ack, busy is the only back-pressure signal. clr beats
// msg_load when both arrive together; a wr_en in the accepting cycle still
// lands because the sequencer does not write until the following cycle.
// -----------------------------------------------------------------------------
module char_text_buffer
  import char_text_buffer_pkg::*;
#(
  parameter  int COLS    = 16,
  parameter  int ROWS    = 16,
  parameter  int CODE_W  = 7,
  parameter  int MAX_LEN = 32,
  localparam int ADDR_W  = $clog2(COLS*ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] char_xy,
  output logic [CODE_W-1:0] code,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              clr,
  input  logic              msg_load,
  input  logic [1:0]        msg_sel,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              busy
);

  localparam int N = COLS*ROWS;
  // idx must be able to hold MAX_LEN itself, and at least feed the 5-bit ROM.
  localparam int IDX_W = ($clog2(MAX_LEN+1) > 5) ? $clog2(MAX_LEN+1) : 5;
  localparam logic [CODE_W-1:0] SPACE = CODE_W'(CHAR_SPACE);
  localparam logic [CODE_W-1:0] NUL   = CODE_W'(CHAR_NUL);

  // ---------------------------------------------------------------------------
  // Sequencer registers
  // ---------------------------------------------------------------------------
  seq_state_t        state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [1:0]        sel, sel_next;
  logic [ADDR_W-1:0] base, base_next;

  logic              seq_we;
  logic [ADDR_W-1:0] seq_addr;
  logic [CODE_W-1:0] seq_data;
  logic [CODE_W-1:0] rom_code;

  char_msg_rom #(.CODE_W(CODE_W)) u_rom (
    .msg_sel (sel),
    .idx     (idx[4:0]),
    .code    (rom_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      ptr   <= '0;
      idx   <= '0;
      sel   <= '0;
      base  <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      idx   <= idx_next;
      sel   <= sel_next;
      base  <= base_next;
      busy  <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    idx_next   = idx;
    sel_next   = sel;
    base_next  = base;
    seq_we     = 1'b0;
    seq_addr   = ptr;
    seq_data   = SPACE;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          state_next = ST_CLEAR;
          ptr_next   = '0;
        end else if (msg_load) begin
          state_next = ST_LOAD;
          sel_next   = msg_sel;
          base_next  = load_addr;
          idx_next   = '0;
        end
      end
      ST_CLEAR: begin
        seq_we   = 1'b1;
        seq_addr = ptr;
        seq_data = SPACE;
        ptr_next = ptr + 1'b1;
        if (ptr == ADDR_W'(N-1)) state_next = ST_IDLE;
      end
      ST_LOAD: begin
        // The terminating cycle (NUL or length limit) performs no write,
        // which is why a load of L characters takes L+1 cycles.
        if (rom_code == NUL || idx == IDX_W'(MAX_LEN)) begin
          state_next = ST_IDLE;
        end else begin
          seq_we   = 1'b1;
          // N is a power of two, so the natural adder overflow is the wrap.
          seq_addr = base + ADDR_W'(idx);
          seq_data = rom_code;
          idx_next = idx + 1'b1;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage: one write port (sequencer first, then direct), one read port.
  // ---------------------------------------------------------------------------
  logic [CODE_W-1:0] mem [N];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [CODE_W-1:0] mem_data;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_addr;
    mem_data = wr_code;
    if (seq_we) begin
      mem_we   = 1'b1;
      mem_addr = seq_addr;
      mem_data = seq_data;
    end else if (wr_en && !busy) begin
      mem_we   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_addr] <= mem_data;
  end

  // Read-first: the array read sees the value before this edge's write.
  always_ff @(posedge clk) begin
    if (rst) code <= SPACE;
    else     code <= mem[char_xy];
  end

endmodule

// File: tb/tb_char_text_buffer.sv
module tb_char_text_buffer;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_xy;
  logic [6:0] code;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [6:0] wr_code;
  logic       clr;
  logic       msg_load;
  logic [1:0] msg_sel;
  logic [7:0] load_addr;
  logic       busy;

  char_text_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .char_xy   (char_xy),
    .code      (code),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_code   (wr_code),
    .clr       (clr),
    .msg_load  (msg_load),
    .msg_sel   (msg_sel),
    .load_addr (load_addr),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] model [N];
  string      msgs [4] = '{"Single Player", "Multi Player", "Game Over", "Press Start"};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, compare on the next falling edge.
  task automatic read_check(input logic [7:0] addr, input string tag);
    logic [6:0] e;
    char_xy = addr;
    exp_q.push_back(model[addr]);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("%s[%02h]", tag, addr), {25'h0, code}, {25'h0, e});
  endtask

  task automatic scan_all(input string tag);
    for (int i = 0; i < N; i++) read_check(8'(i), tag);
  endtask

  task automatic model_fill_space();
    for (int i = 0; i < N; i++) model[i] = 7'h20;
  endtask

  task automatic model_load(input int sel, input logic [7:0] addr);
    for (int i = 0; i < msgs[sel].len() && i < 32; i++)
      model[8'(addr + 8'(i))] = 7'(msgs[sel][i]);
  endtask

  // Counts falling-edge samples with busy=1, starting at the current one.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic issue_load(input logic [1:0] sel, input logic [7:0] addr);
    msg_load  = 1'b1;
    msg_sel   = sel;
    load_addr = addr;
    @(negedge clk);
    msg_load  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int cnt;

  initial begin
    rst = 1'b1; char_xy = '0; wr_en = 1'b0; wr_addr = '0; wr_code = '0;
    clr = 1'b0; msg_load = 1'b0; msg_sel = '0; load_addr = '0;

    // Reset: 3 cycles, code and busy held.
    repeat (3) @(negedge clk);
    check("reset_code", {25'h0, code}, 32'h20);
    check("reset_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    count_busy(cnt);
    check("reset_clear_len", cnt, 256);
    model_fill_space();
    scan_all("after_reset");

    // Direct write with same-cycle read of the same cell (read-first).
    wr_en = 1'b1; wr_addr = 8'h35; wr_code = 7'h41;
    char_xy = 8'h35;
    exp_q.push_back(7'h20);
    @(negedge clk);
    wr_en = 1'b0;
    check("read_first", {25'h0, code}, {25'h0, exp_q.pop_front()});
    model[8'h35] = 7'h41;
    read_check(8'h35, "direct_wr");

    // Load "Multi Player" at 0x12.
    issue_load(2'd1, 8'h12);
    count_busy(cnt);
    check("load_multi_len", cnt, 13);
    model_load(1, 8'h12);
    check("model_12", {25'h0, model[8'h12]}, 32'h4D);
    check("model_17", {25'h0, model[8'h17]}, 32'h20);
    check("model_1d", {25'h0, model[8'h1D]}, 32'h72);
    read_check(8'h12, "multi");
    read_check(8'h17, "multi");
    read_check(8'h1D, "multi");
    read_check(8'h1E, "multi_end");

    // Load "Game Over" at 0xFC, wrapping past the last cell.
    issue_load(2'd2, 8'hFC);
    count_busy(cnt);
    check("load_wrap_len", cnt, 10);
    model_load(2, 8'hFC);
    scan_all("wrap");

    // "Press Start" at 0x80; during the load try a direct write and a
    // second msg_load, both of which must be ignored.
    msg_load = 1'b1; msg_sel = 2'd3; load_addr = 8'h80;
    @(negedge clk);
    msg_load = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      if (cnt == 2) begin
        wr_en = 1'b1; wr_addr = 8'h40; wr_code = 7'h41;
        msg_load = 1'b1; msg_sel = 2'd0; load_addr = 8'h60;
      end else begin
        wr_en = 1'b0; msg_load = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; msg_load = 1'b0;
    check("load_start_len", cnt, 12);
    repeat (3) @(negedge clk);
    check("ignored_load_idle", {31'h0, busy}, 32'h0);
    model_load(3, 8'h80);
    scan_all("busy_ignore");

    // clr and msg_load together: only the clear happens.
    clr = 1'b1; msg_load = 1'b1; msg_sel = 2'd0; load_addr = 8'h00;
    @(negedge clk);
    clr = 1'b0; msg_load = 1'b0;
    count_busy(cnt);
    check("clr_wins_len", cnt, 256);
    repeat (2) @(negedge clk);
    check("clr_wins_idle", {31'h0, busy}, 32'h0);
    model_fill_space();
    scan_all("clr_wins");

    // Reset five cycles into loading "Single Player".
    issue_load(2'd0, 8'h30);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midload_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    count_busy(cnt);
    check("midload_clear_len", cnt, 256);
    scan_all("midload");

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
